// File: rtl/mux_nx1_pipe_if.sv
// Handshake bundle for mux_nx1_pipe: flattened operand channels in, selected operand out.
interface mux_nx1_pipe_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    sel_err;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, sel_err
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, sel_err
  );
endinterface

// File: rtl/mux_nx1_pipe.sv
// Registered N:1 operand-select mux with a 2-entry skid buffer (main + skid) and valid/ready.
// Define MUX_NX1_SEL_ERR_EN to build the sticky out-of-range select flag (sel_err).
module mux_nx1_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_nx1_pipe_if.slave     bus
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic [SEL_W-1:0] main_sel_q,   main_sel_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic [SEL_W-1:0] skid_sel_q,   skid_sel_d;
  logic             in_ready_q,   in_ready_d;

  logic             accept_c;
  logic             drain_c;
  logic [WIDTH-1:0] sel_data_c;

  assign accept_c = bus.in_valid & in_ready_q;
  assign drain_c  = main_valid_q & bus.out_ready;

  // Decoded AND-OR select; an out-of-range code matches no channel and yields zero.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      sel_data_c = sel_data_c
                 | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{bus.in_sel == SEL_W'(i)}});
    end
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;

    if (drain_c && skid_valid_q) begin
      // in_ready is low while skid is occupied, so no accept can coincide here.
      main_valid_d = 1'b1;
      main_data_d  = skid_data_q;
      main_sel_d   = skid_sel_q;
      skid_valid_d = 1'b0;
    end else if (accept_c && (!main_valid_q || drain_c)) begin
      main_valid_d = 1'b1;
      main_data_d  = sel_data_c;
      main_sel_d   = bus.in_sel;
    end else if (accept_c) begin
      skid_valid_d = 1'b1;
      skid_data_d  = sel_data_c;
      skid_sel_d   = bus.in_sel;
    end else if (drain_c) begin
      main_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_sel   = main_sel_q;

`ifdef MUX_NX1_SEL_ERR_EN
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

  logic sel_err_q, sel_err_d;

  // Sticky until reset; the offending beat still passes with zero data.
  always_comb begin
    sel_err_d = sel_err_q | (accept_c & ({1'b0, bus.in_sel} >= NUM_IN_L));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Scoreboard bench for mux_nx1_pipe: a NUM_IN=4 instance and a NUM_IN=3 instance for out-of-range selects.
module tb_mux_nx1_pipe;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
  } exp_t;

`ifdef MUX_NX1_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  mux_nx1_pipe_if #(.WIDTH(32), .NUM_IN(4)) ifa ();
  mux_nx1_pipe_if #(.WIDTH(32), .NUM_IN(3)) ifb ();

  mux_nx1_pipe #(.WIDTH(32), .NUM_IN(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mux_nx1_pipe #(.WIDTH(32), .NUM_IN(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] chan_a [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat; the expectation is queued only once the DUT is ready to take it.
  task automatic send(input bit to_b, input logic [1:0] sel, input logic [31:0] exp_data);
    exp_t e;
    int   w;
    e.data = exp_data;
    e.sel  = sel;
    w      = 0;
    if (to_b) begin ifb.in_valid = 1'b1; ifb.in_sel = sel; end
    else      begin ifa.in_valid = 1'b1; ifa.in_sel = sel; end
    while (!(to_b ? ifb.in_ready : ifa.in_ready) && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) begin
      chk("send_ready_timeout", 32'd0, 32'd1);
    end else begin
      if (to_b) exp_b.push_back(e);
      else      exp_a.push_back(e);
      tick();
    end
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  // Monitors: pop and compare on every output handshake.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && ifa.out_valid && ifa.out_ready) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_a.pop_front();
        chk("a_out_data", ifa.out_data, e.data);
        chk("a_out_sel", 32'(ifa.out_sel), 32'(e.sel));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && ifb.out_valid && ifb.out_ready) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_b.pop_front();
        chk("b_out_data", ifb.out_data, e.data);
        chk("b_out_sel", 32'(ifb.out_sel), 32'(e.sel));
      end
    end
  end

  initial begin
    chan_a[0] = 32'hAAAA0000;
    chan_a[1] = 32'hBBBB0001;
    chan_a[2] = 32'hCCCC0002;
    chan_a[3] = 32'hDDDD0003;

    rst_n         = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.in_sel    = '0;
    ifa.in_data   = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    ifa.out_ready = 1'b1;
    ifb.in_valid  = 1'b0;
    ifb.in_sel    = '0;
    ifb.in_data   = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    ifb.out_ready = 1'b1;

    // Reset held for three cycles.
    repeat (3) tick();
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_out_data", ifa.out_data, 32'd0);
    chk("rst_out_sel", 32'(ifa.out_sel), 32'd0);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst_sel_err", 32'(ifa.sel_err), 32'd0);
    chk("rst_b_in_ready", 32'(ifb.in_ready), 32'd0);

    rst_n = 1'b1;
    tick();
    chk("release_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("release_out_valid", 32'(ifa.out_valid), 32'd0);

    // Single beat, one-cycle latency.
    send(1'b0, 2'd2, 32'hCCCC0002);
    chk("single_out_valid", 32'(ifa.out_valid), 32'd1);
    chk("single_out_data", ifa.out_data, 32'hCCCC0002);
    chk("single_out_sel", 32'(ifa.out_sel), 32'd2);
    tick();
    chk("single_drained", 32'(ifa.out_valid), 32'd0);

    // Streaming: eight back-to-back beats.
    for (int i = 0; i < 8; i++) begin
      chk("stream_in_ready", 32'(ifa.in_ready), 32'd1);
      send(1'b0, 2'(i % 4), chan_a[i % 4]);
      chk("stream_out_valid", 32'(ifa.out_valid), 32'd1);
    end
    repeat (2) tick();
    chk("stream_idle", 32'(ifa.out_valid), 32'd0);

    // Backpressure fills main then skid.
    ifa.out_ready = 1'b0;
    send(1'b0, 2'd1, 32'hBBBB0001);
    send(1'b0, 2'd3, 32'hDDDD0003);
    chk("bp_in_ready_low", 32'(ifa.in_ready), 32'd0);
    chk("bp_hold_data", ifa.out_data, 32'hBBBB0001);
    repeat (2) tick();
    chk("bp_hold_data_later", ifa.out_data, 32'hBBBB0001);
    chk("bp_hold_sel_later", 32'(ifa.out_sel), 32'd1);
    chk("bp_in_ready_still_low", 32'(ifa.in_ready), 32'd0);
    ifa.out_ready = 1'b1;
    tick();
    chk("bp_skid_to_main", ifa.out_data, 32'hDDDD0003);
    chk("bp_in_ready_back", 32'(ifa.in_ready), 32'd1);
    repeat (2) tick();

    // Out-of-range select on the 3-channel instance.
    send(1'b1, 2'd1, 32'hBBBB0001);
    chk("b_sel_err_clean", 32'(ifb.sel_err), 32'd0);
    send(1'b1, 2'd3, 32'h00000000);
    chk("b_oor_data", ifb.out_data, 32'h00000000);
    chk("b_sel_err_set", 32'(ifb.sel_err), 32'(ERR_EN));
    send(1'b1, 2'd2, 32'hCCCC0002);
    send(1'b1, 2'd0, 32'hAAAA0000);
    repeat (2) tick();
    chk("b_sel_err_sticky", 32'(ifb.sel_err), 32'(ERR_EN));
    chk("a_sel_err_pow2", 32'(ifa.sel_err), 32'd0);

    // Mid-operation reset with both entries full.
    ifa.out_ready = 1'b0;
    send(1'b0, 2'd0, 32'hAAAA0000);
    send(1'b0, 2'd1, 32'hBBBB0001);
    chk("mid_full", 32'(ifa.in_ready), 32'd0);
    exp_a.delete();
    exp_b.delete();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("mid_rst_out_data", ifa.out_data, 32'd0);
    chk("mid_rst_b_sel_err", 32'(ifb.sel_err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_release_in_ready", 32'(ifa.in_ready), 32'd1);
    ifa.out_ready = 1'b1;
    send(1'b0, 2'd3, 32'hDDDD0003);
    chk("mid_first_beat", ifa.out_data, 32'hDDDD0003);

    for (int w = 0; w < 20 && (exp_a.size() != 0 || exp_b.size() != 0); w++) tick();
    repeat (2) tick();
    chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised N:1 operand-select mux with a registered output and a valid/ready handshake. It succeeds the fixed 32-bit 2:1 select in the execute stage.
- Sits between the forwarding/operand sources and the ALU input register.
- Captures the selected operand together with its select code in one cycle.
- A 2-entry skid buffer gives full throughput while keeping in_ready registered.

Parameters:
- WIDTH, 32, data width per channel (>=1)
- NUM_IN, 4, number of input channels (>=2)
- SEL_W, $clog2(NUM_IN), select width; derived, do not override

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept a beat
- in_sel  input  SEL_W  channel select, sampled with the beat
- in_data  input  NUM_IN*WIDTH  flattened channels; channel i = in_data[i*WIDTH +: WIDTH]
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  selected operand
- out_sel  output  SEL_W  select code that produced out_data
- sel_err  output  1  sticky out-of-range select flag (see Optional Feature)

Behaviour:
- Reset is synchronous and active-low: clk is the only clock, and rst_n is sampled on the rising edge.
- While rst_n=0 the block holds out_valid=0, out_data=0, out_sel=0, sel_err=0, in_ready=0, and the skid entry is empty.
- in_ready goes to 1 on the first edge with rst_n=1.
- Select function:
  - sel < NUM_IN: result = channel sel.
  - sel >= NUM_IN (only possible when NUM_IN is not a power of 2): result = all zeros.
  - The select logic has no priority; it is a decoded AND-OR.
- Storage is two entries:
  - main: drives out_*.
  - skid: holds data, sel and a valid bit.
- in_ready = ~skid_valid, driven from a register and not combinational from out_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Per-edge update:
  - Drain and skid valid: main <= skid; skid empties. If Accept is also high, the new beat goes into skid. This cannot happen, because in_ready=0 while skid is valid.
  - Accept and (main empty or Drain): main <= new beat.
  - Accept, main full and no Drain: skid <= new beat; in_ready drops the next cycle.
  - Drain, no Accept, skid empty: out_valid <= 0. out_data and out_sel hold their last values.
- Latency: 1 cycle from Accept to out_valid when main is empty. Throughput: 1 beat per cycle with out_ready held high.
- Ordering is strictly FIFO: a beat in skid always exits after the main beat.
- Stability: while out_valid=1 and out_ready=0, out_data and out_sel must not change.
- in_data and in_sel are ignored when Accept=0.
- Reset mid-operation: both entries are discarded with no drain. Beats in flight are lost by design.

Optional Feature:
- Macro: MUX_NX1_SEL_ERR_EN
- Defined:
  - sel_err is set on the edge after any Accept with in_sel >= NUM_IN.
  - It stays set until reset.
  - The beat still passes with zero data.
- Undefined:
  - sel_err is tied to 0 and no flag register is built.
  - Data behaviour is identical.
- When NUM_IN is a power of 2, sel_err is always 0 with or without the macro.

Test Plan:
- Reset, then release; NUM_IN=4, WIDTH=32:
  - Hold rst_n=0 for 3 cycles -> out_valid=0, out_data=0, in_ready=0.
  - Release -> in_ready=1 next edge.
- Single beat:
  - in_data channels = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, in_sel=2, in_valid pulse, out_ready=1.
  - -> next cycle out_valid=1, out_data=0xCCCC0002, out_sel=2.
- Streaming:
  - 8 back-to-back beats with sel cycling 0..3, out_ready=1.
  - -> 8 outputs on consecutive cycles in order; in_ready stays 1.
- Backpressure/skid:
  - out_ready=0, send beats with sel=1 then sel=3.
  - -> in_ready=0 after the second beat; out_data stays the sel=1 value.
  - Raise out_ready -> sel=1 value, then sel=3 value; in_ready returns to 1.
- Out-of-range, NUM_IN=3 with macro defined:
  - Accept in_sel=3 -> out_data=0; sel_err=1 and stays 1 across later valid beats until rst_n=0.
  - Without the macro: sel_err=0.
- Mid-operation reset:
  - Both entries full, assert rst_n=0 for 1 cycle.
  - -> out_valid=0, skid empty; the next accepted beat is the first one seen at the output.
